// File: rtl/alarm_sched_pkg.sv
// Shared encodings for the alarm zone scheduler: FSM states and zone count.
package alarm_sched_pkg;

    localparam int NUM_ZONES = 4;

    typedef enum logic [1:0] {
        DISARMED = 2'b00,
        ARMED    = 2'b01,
        DELAY    = 2'b10,
        ALARM    = 2'b11
    } state_t;

endpackage

// File: rtl/rr_picker4.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping 3->0.
module rr_picker4
    import alarm_sched_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] idx,
    output logic       valid
);

    // Scan from farthest to nearest so the closest candidate is assigned last and wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = NUM_ZONES - 1; i >= 0; i--) begin
            if (req[ptr + 2'(i)]) begin
                idx   = ptr + 2'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alarm_zone_scheduler.sv
// Alarm panel scheduler: arms, latches zone trips, runs an entry delay, then
// sounds the siren and reports tripped zones one at a time in round-robin order.
module alarm_zone_scheduler
    import alarm_sched_pkg::*;
#(
    parameter int DELAY_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arm,
    input  logic       disarm,
    input  logic [3:0] zone_req,
    input  logic       report_ready,
    output logic [1:0] state,
    output logic       siren,
    output logic       report_valid,
    output logic [1:0] report_zone,
    output logic [3:0] pending,
    output logic [7:0] event_count
);

    state_t     st_q, st_n;
    logic [3:0] pend_q, pend_upd, pend_n;
    logic [7:0] cnt_q, cnt_n;
    logic [1:0] ptr_q, ptr_upd;
    logic [1:0] zone_q, zone_n;
    logic [7:0] evt_q, evt_upd;
    logic       valid_q, valid_n;
    logic       siren_q, siren_n;
    logic       accept;
    logic [1:0] pick_idx;
    logic       pick_valid;

    assign accept = valid_q & report_ready;

    // Sticky trips, acceptance bookkeeping and pointer advance. A new request on
    // the accepted bit re-sets it in the same cycle.
    always_comb begin
        pend_upd = pend_q;
        ptr_upd  = ptr_q;
        evt_upd  = evt_q;
        if (st_q != DISARMED) begin
            pend_upd = pend_q | zone_req;
        end
        if (accept) begin
            pend_upd = (pend_q & ~(4'b0001 << zone_q)) | zone_req;
            ptr_upd  = zone_q + 2'd1;
            evt_upd  = (evt_q == 8'hFF) ? evt_q : evt_q + 8'd1;
        end
    end

    rr_picker4 u_picker (
        .req   (pend_upd),
        .ptr   (ptr_upd),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        st_n    = st_q;
        cnt_n   = cnt_q;
        zone_n  = zone_q;
        valid_n = valid_q;
        pend_n  = pend_upd;
        case (st_q)
            DISARMED: begin
                if (arm) st_n = ARMED;
            end
            ARMED: begin
                if (pick_valid) begin
                    zone_n = pick_idx;
                    cnt_n  = 8'(DELAY_CYCLES - 1);
                    st_n   = DELAY;
                end
            end
            DELAY: begin
                if (cnt_q == 8'd0) begin
                    st_n    = ALARM;
                    valid_n = 1'b1;
                end else begin
                    cnt_n = cnt_q - 8'd1;
                end
            end
            ALARM: begin
                // Present the next zone straight after acceptance, or any trip seen while idle.
                if (accept || !valid_q) begin
                    valid_n = pick_valid;
                    if (pick_valid) zone_n = pick_idx;
                end
            end
            default: st_n = DISARMED;
        endcase
        if (disarm) begin
            st_n    = DISARMED;
            cnt_n   = '0;
            zone_n  = '0;
            valid_n = 1'b0;
            pend_n  = '0;
        end
        siren_n = (st_n == ALARM);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= DISARMED;
            pend_q  <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            zone_q  <= '0;
            evt_q   <= '0;
            valid_q <= 1'b0;
            siren_q <= 1'b0;
        end else begin
            st_q    <= st_n;
            pend_q  <= pend_n;
            cnt_q   <= cnt_n;
            ptr_q   <= ptr_upd;
            zone_q  <= zone_n;
            evt_q   <= evt_upd;
            valid_q <= valid_n;
            siren_q <= siren_n;
        end
    end

    assign state        = st_q;
    assign siren        = siren_q;
    assign report_valid = valid_q;
    assign report_zone  = zone_q;
    assign pending      = pend_q;
    assign event_count  = evt_q;

endmodule

// File: tb/tb_alarm_zone_scheduler.sv
// Directed bench for alarm_zone_scheduler with DELAY_CYCLES=4 and hand-computed expectations.
module tb_alarm_zone_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       arm = 1'b0;
    logic       disarm = 1'b0;
    logic [3:0] zone_req = 4'b0000;
    logic       report_ready = 1'b0;
    logic [1:0] state;
    logic       siren;
    logic       report_valid;
    logic [1:0] report_zone;
    logic [3:0] pending;
    logic [7:0] event_count;

    int n_checks = 0;
    int n_pass   = 0;

    alarm_zone_scheduler #(.DELAY_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arm          (arm),
        .disarm       (disarm),
        .zone_req     (zone_req),
        .report_ready (report_ready),
        .state        (state),
        .siren        (siren),
        .report_valid (report_valid),
        .report_zone  (report_zone),
        .pending      (pending),
        .event_count  (event_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_state", 32'(state), 0);
        check("rst_siren", 32'(siren), 0);
        check("rst_valid", 32'(report_valid), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_count", 32'(event_count), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single zone 2 trip, delay of 4 cycles, then report
        arm = 1'b1;
        tick();
        check("s1_armed", 32'(state), 1);
        arm = 1'b0;
        zone_req = 4'b0100;
        tick();
        zone_req = 4'b0000;
        check("s1_delay_entry", 32'(state), 2);
        check("s1_pending", 32'(pending), 4'b0100);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s1_delay_hold", 32'(state), 2);
            check("s1_delay_siren", 32'(siren), 0);
        end
        tick();
        check("s1_alarm", 32'(state), 3);
        check("s1_siren", 32'(siren), 1);
        check("s1_valid", 32'(report_valid), 1);
        check("s1_zone", 32'(report_zone), 2);
        report_ready = 1'b1;
        tick();
        report_ready = 1'b0;
        check("s1_pending_clr", 32'(pending), 0);
        check("s1_count", 32'(event_count), 1);
        check("s1_valid_drop", 32'(report_valid), 0);
        check("s1_stay_alarm", 32'(state), 3);
        check("s1_siren_on", 32'(siren), 1);

        // Asynchronous reset mid-ALARM
        #3 rst_n = 1'b0;
        #1;
        check("ar_state", 32'(state), 0);
        check("ar_siren", 32'(siren), 0);
        check("ar_zone", 32'(report_zone), 0);
        check("ar_count", 32'(event_count), 0);
        check("ar_pending", 32'(pending), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Three simultaneous trips drained back to back from pointer 0
        arm = 1'b1;
        tick();
        arm = 1'b0;
        zone_req = 4'b1011;
        report_ready = 1'b1;
        tick();
        zone_req = 4'b0000;
        check("s2_delay", 32'(state), 2);
        tick(3);
        check("s2_still_delay", 32'(state), 2);
        tick();
        check("s2_alarm", 32'(state), 3);
        check("s2_zone0", 32'(report_zone), 0);
        check("s2_valid0", 32'(report_valid), 1);
        tick();
        check("s2_zone1", 32'(report_zone), 1);
        check("s2_valid1", 32'(report_valid), 1);
        check("s2_count1", 32'(event_count), 1);
        tick();
        check("s2_zone3", 32'(report_zone), 3);
        check("s2_valid3", 32'(report_valid), 1);
        tick();
        report_ready = 1'b0;
        check("s2_valid_end", 32'(report_valid), 0);
        check("s2_count3", 32'(event_count), 3);
        check("s2_pending", 32'(pending), 0);
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        check("s2_disarmed", 32'(state), 0);
        check("s2_siren_off", 32'(siren), 0);

        // Disarm while the delay counter reads 2
        arm = 1'b1;
        tick();
        arm = 1'b0;
        zone_req = 4'b0001;
        tick();
        zone_req = 4'b0000;
        tick();
        check("s3_delay", 32'(state), 2);
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        check("s3_state", 32'(state), 0);
        check("s3_siren", 32'(siren), 0);
        check("s3_pending", 32'(pending), 0);
        check("s3_count", 32'(event_count), 3);

        // Backpressure for 10 cycles, then re-trip on the accepted bit
        arm = 1'b1;
        tick();
        arm = 1'b0;
        zone_req = 4'b0100;
        tick();
        zone_req = 4'b0000;
        tick(4);
        check("s4_alarm", 32'(state), 3);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("s4_hold_valid", 32'(report_valid), 1);
            check("s4_hold_zone", 32'(report_zone), 2);
        end
        report_ready = 1'b1;
        zone_req = 4'b0100;
        tick();
        report_ready = 1'b0;
        zone_req = 4'b0000;
        check("s4_pending_kept", 32'(pending), 4'b0100);
        check("s4_count", 32'(event_count), 4);
        check("s4_represent", 32'(report_valid), 1);

        // arm and disarm together stay disarmed
        disarm = 1'b1;
        tick();
        check("ad_disarm", 32'(state), 0);
        arm = 1'b1;
        tick();
        check("ad_both", 32'(state), 0);
        arm = 1'b0;
        disarm = 1'b0;
        tick();
        check("ad_idle", 32'(state), 0);

        // Saturation of event_count with a held trip and ready always high
        arm = 1'b1;
        tick();
        arm = 1'b0;
        zone_req = 4'b0001;
        report_ready = 1'b1;
        tick(5);
        check("s5_alarm", 32'(state), 3);
        check("s5_count_start", 32'(event_count), 4);
        tick(251);
        check("s5_count_255", 32'(event_count), 255);
        tick(10);
        check("s5_count_sat", 32'(event_count), 255);
        check("s5_valid", 32'(report_valid), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
